tea_decrypt_core: RTL

//  Iterative multi-round TEA decryption engine: the inverse direction of the single-round
//  TEA datapath. Accepts one 64-bit ciphertext block (black/red halves) plus 128-bit key,

---
 rtl/tea_decrypt_core.sv | 117 +++++++++++
 1 files changed

// File: rtl/tea_decrypt_core.sv
// Iterative TEA decryption engine: undoes ROUNDS forward TEA cycles, one inverse round per clock.
// A block is latched on an accepted start; outputs hold the last plaintext until the next completion.
module tea_decrypt_core #(
    parameter int          ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [31:0]  inBlack,
    input  logic [31:0]  inRed,
    output logic         busy,
    output logic         done,
    output logic [31:0]  outBlack,
    output logic [31:0]  outRed
);

    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  RUN      = 2'd1;
    localparam logic [1:0]  DONE     = 2'd2;
    // Final forward sum; the inverse schedule walks it back down to zero.
    localparam logic [31:0] SUM_INIT = 32'(DELTA * 32'(ROUNDS));
    localparam logic [6:0]  LAST_CNT = 7'(ROUNDS - 1);

    function automatic logic [31:0] tea_f(
        input logic [31:0] v,
        input logic [31:0] ka,
        input logic [31:0] kb,
        input logic [31:0] s
    );
        return ((v << 3'd4) + ka) ^ (v + s) ^ ((v >> 3'd5) + kb);
    endfunction

    logic [1:0]   state_r;
    logic [6:0]   cnt_r;
    logic [127:0] key_r;
    logic [31:0]  black_r;
    logic [31:0]  red_r;
    logic [31:0]  sum_r;
    logic         busy_r;
    logic         done_r;
    logic [31:0]  out_black_r;
    logic [31:0]  out_red_r;

    logic [31:0]  black_nxt_s;
    logic [31:0]  red_nxt_s;
    logic [31:0]  sum_nxt_s;

    // One inverse round on the latched state; red uses the already-updated black.
    always_comb begin
        black_nxt_s = 32'h0000_0000;
        red_nxt_s   = 32'h0000_0000;
        sum_nxt_s   = 32'h0000_0000;
        black_nxt_s = black_r - tea_f(red_r, key_r[63:32], key_r[31:0], sum_r);
        red_nxt_s   = red_r - tea_f(black_nxt_s, key_r[127:96], key_r[95:64], sum_r);
        sum_nxt_s   = sum_r - DELTA;
    end

    // Control FSM and datapath registers; reset wins over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 7'd0;
            key_r       <= 128'd0;
            black_r     <= 32'h0000_0000;
            red_r       <= 32'h0000_0000;
            sum_r       <= 32'h0000_0000;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_black_r <= 32'h0000_0000;
            out_red_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        key_r   <= key;
                        black_r <= inBlack;
                        red_r   <= inRed;
                        sum_r   <= SUM_INIT;
                        cnt_r   <= 7'd0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    black_r <= black_nxt_s;
                    red_r   <= red_nxt_s;
                    sum_r   <= sum_nxt_s;
                    if (cnt_r == LAST_CNT) begin
                        out_black_r <= black_nxt_s;
                        out_red_r   <= red_nxt_s;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 7'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign outBlack = out_black_r;
    assign outRed   = out_red_r;

endmodule
